pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Two-entry valid/ready skid register placed between CPU pipeline stages.
//  Consumer side of an enabled stage register: accepts a beat from the upstream stage, holds it, presents it downstream.
//  Fully registered in both directions: in_ready is a flop, out_valid/out_data are flops.
//  Upstream stays unstalled for one cycle after downstream deasserts out_ready.
// PARAMETERS
//  WIDTH   32   payload width in bits
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst_n      in   1      synchronous, active-low reset (sampled on posedge clk only)
//  in_data    in   WIDTH  upstream payload
//  in_valid   in   1      upstream beat present
//  in_ready   out  1      block can accept a beat this cycle
//  out_data   out  WIDTH  downstream payload (main slot)
//  out_valid  out  1      main slot holds a beat
//  out_ready  in   1      downstream accepts this cycle
//  count      out  2      occupancy 0..2
//  flush      in   1      (only with PIPE_SKID_FLUSH_EN) discard all held beats
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - States (encoded by occupancy):
//    EMPTY  - count=0, in_ready=1, out_valid=0.
//    BUSY   - count=1, main slot full, in_ready=1, out_valid=1.
//    FULL   - count=2, main and skid slots full, in_ready=0, out_valid=1.
//  - EMPTY: in_fire -> main<=in_data, go BUSY. Latency in->out is 1 cycle. No combinational in->out path.
//  - BUSY:
//    - in_fire & out_fire -> main<=in_data, stay BUSY.
//    - in_fire only -> skid<=in_data, go FULL.
//    - out_fire only -> go EMPTY.
//  - FULL: in_valid ignored (in_ready=0). out_fire -> main<=skid, go BUSY.
//  - Ordering is strict FIFO. No beat is dropped or duplicated except by flush/reset.
//  - Payload slots hold their last value when vacated. out_data is defined only while out_valid=1.
//  - Reset (rst_n=0 at posedge):
//    - state EMPTY, main=skid=0.
//    - outputs after that edge: out_valid=0, out_data=0, count=0, in_ready=1.
//    - Mid-operation reset discards held beats. Same-cycle in_valid is ignored.
//  - Priority: reset > flush > normal handshake.
// CONFIGURATION
//  - PIPE_SKID_FLUSH_EN defined:
//    - flush port present.
//    - flush=1 at posedge -> state EMPTY, out_valid=0, count=0, in_ready=1 next cycle.
//    - Same-cycle in_fire beat is discarded. Same-cycle out_fire still counts as consumed by downstream.
//    - Payload slots unchanged.
//  - Not defined: no flush port; block only empties by draining or reset.
// STRUCTURE
//  - Shared header pipe_defs.vh: state localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
//    The same encodings are reused by the hazard/stall unit.
//  - One sub-module pipe_slot: WIDTH-bit data flop with load enable and synchronous active-low clear.
//    Instantiated twice (main, skid).
//  - Control FSM stays inline.
// TESTING
//  1. Reset: hold rst_n=0 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF
//     -> out_valid=0, out_data=0, count=0, in_ready=1.
//  2. Stream: out_ready=1, push 1,2,3 on consecutive cycles
//     -> out_data 1,2,3 one cycle later each, count stays 1, in_ready=1 throughout.
//  3. Backpressure: out_ready=0, push 32'hA then 32'hB
//     -> count=2, in_ready=0, out_data=32'hA.
//     Raise out_ready -> 32'hA then 32'hB, in_ready=1 the cycle after the first pop.
//  4. FULL hold: FULL with in_valid=1, in_data=32'hC for 3 cycles, out_ready=0
//     -> 32'hC never captured. After draining, only A and B appear.
//  5. Mid-operation reset: FULL, then rst_n=0 one cycle
//     -> EMPTY. Next push 32'h5 appears alone, 1-cycle latency.
//  6. (PIPE_SKID_FLUSH_EN) Flush: FULL, then flush=1 with in_valid=1, in_data=32'h7
//     -> next cycle count=0, out_valid=0. 32'h7 never emitted.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-handshake definitions: occupancy-encoded state names reused by
// the hazard/stall unit, plus an occupancy decode helper.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_SKID_WIDTH_DEF = 32;

    function automatic logic [1:0] state_occupancy(input pipe_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_BUSY:  occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_slot.sv
// One payload slot of the skid register: WIDTH-bit flop with load enable and
// synchronous active-low clear.
module pipe_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Payload storage; clear wins over load, otherwise the slot holds its value.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            data_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry, fully registered valid/ready skid register between pipeline stages.
// Optional flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_SKID_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic             flush,
`endif
    output logic [1:0]       count
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       count_q;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             flush_s;
    logic             load_main_s;
    logic             load_skid_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = out_valid_q & out_ready;

    // Next-state and slot-load decode; flush overrides the handshake and loads nothing.
    always_comb begin
        state_d     = state_q;
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        main_d_s    = in_data;
        if (flush_s) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        load_main_s = 1'b1;
                        state_d     = ST_BUSY;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        load_main_s = 1'b1;
                        state_d     = ST_BUSY;
                    end else if (in_fire_s) begin
                        load_skid_s = 1'b1;
                        state_d     = ST_FULL;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    main_d_s = skid_q_s;
                    if (out_fire_s) begin
                        load_main_s = 1'b1;
                        state_d     = ST_BUSY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with handshake outputs precomputed from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            count_q     <= state_occupancy(state_d);
        end
    end

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk     (clk),
        .clr_n_i (rst_n),
        .load_i  (load_main_s),
        .d_i     (main_d_s),
        .q_o     (main_q_s)
    );

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .clr_n_i (rst_n),
        .load_i  (load_skid_s),
        .d_i     (in_data),
        .q_o     (skid_q_s)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q_s;
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; flush case runs only when
// PIPE_SKID_FLUSH_EN is defined.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;
`ifdef PIPE_SKID_FLUSH_EN
    logic        flush;
`endif

    int checks_r;
    int errors_r;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
        .flush     (flush),
`endif
        .count     (count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples settle 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] cnt, input logic ov,
                             input logic ir);
        chk({tag, ".count"}, {30'd0, count}, {30'd0, cnt});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    endtask

    // Push A then B with downstream stalled, leaving the block FULL.
    task automatic fill_ab();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data   = 32'hB;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        checks_r  = 0;
        errors_r  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
        flush     = 1'b0;
`endif
        #1;

        // 1. reset held two cycles with a beat offered
        step();
        step();
        chk_state("rst", 2'd0, 1'b0, 1'b1);
        chk("rst.out_data", out_data, 32'd0);

        // 2. streaming with downstream always ready
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'd1;
        step();
        chk_state("s1", 2'd1, 1'b1, 1'b1);
        chk("s1.data", out_data, 32'd1);
        in_data = 32'd2;
        step();
        chk_state("s2", 2'd1, 1'b1, 1'b1);
        chk("s2.data", out_data, 32'd2);
        in_data = 32'd3;
        step();
        chk_state("s3", 2'd1, 1'b1, 1'b1);
        chk("s3.data", out_data, 32'd3);
        in_valid = 1'b0;
        step();
        chk_state("s_drain", 2'd0, 1'b0, 1'b1);

        // 3. backpressure then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk_state("bp1", 2'd1, 1'b1, 1'b1);
        chk("bp1.data", out_data, 32'hA);
        in_data = 32'hB;
        step();
        chk_state("bp2", 2'd2, 1'b1, 1'b0);
        chk("bp2.data", out_data, 32'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_state("bp_pop1", 2'd1, 1'b1, 1'b1);
        chk("bp_pop1.data", out_data, 32'hB);
        step();
        chk_state("bp_pop2", 2'd0, 1'b0, 1'b1);

        // 4. FULL ignores offered beats
        fill_ab();
        in_valid = 1'b1;
        in_data  = 32'hC;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("hold", 2'd2, 1'b1, 1'b0);
            chk("hold.data", out_data, 32'hA);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_state("hold_pop1", 2'd1, 1'b1, 1'b1);
        chk("hold_pop1.data", out_data, 32'hB);
        step();
        chk_state("hold_pop2", 2'd0, 1'b0, 1'b1);

        // 5. reset while FULL, then a fresh beat
        fill_ab();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h9;
        step();
        chk_state("mrst", 2'd0, 1'b0, 1'b1);
        chk("mrst.data", out_data, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h5;
        step();
        chk_state("mrst_push", 2'd1, 1'b1, 1'b1);
        chk("mrst_push.data", out_data, 32'h5);
        in_valid = 1'b0;
        step();
        chk_state("mrst_drain", 2'd0, 1'b0, 1'b1);

`ifdef PIPE_SKID_FLUSH_EN
        // 6. flush while FULL discards held beats and the offered one
        fill_ab();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h7;
        step();
        chk_state("flush", 2'd0, 1'b0, 1'b1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_state("flush_after", 2'd0, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
